// File: rtl/vga_overlay_sched_if.sv
// Pixel-path bundle for the overlay scheduler: timing-generator inputs,
// camera and sprite-ROM data, composed pixel out, configuration handshake
// and frame status. The slave modport is the scheduler side.
interface vga_overlay_sched_if #(
   parameter int ADDR_W = 12
);
   logic              data_en;
   logic [11:0]       x_pos;
   logic [11:0]       y_pos;
   logic [23:0]       cam_data;
   logic [23:0]       rom_q;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [23:0]       pix_data;
   logic              pix_valid;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [11:0]       cfg_x;
   logic [11:0]       cfg_y;
   logic              cfg_ovl_en;
   logic [15:0]       frame_cnt;
   logic              frame_tick;

   modport master (
      output data_en, x_pos, y_pos, cam_data, rom_q,
      output cfg_valid, cfg_x, cfg_y, cfg_ovl_en,
      input  rom_en, rom_addr, pix_data, pix_valid,
      input  cfg_ready, frame_cnt, frame_tick
   );

   modport slave (
      input  data_en, x_pos, y_pos, cam_data, rom_q,
      input  cfg_valid, cfg_x, cfg_y, cfg_ovl_en,
      output rom_en, rom_addr, pix_data, pix_valid,
      output cfg_ready, frame_cnt, frame_tick
   );
endinterface

// File: rtl/vga_overlay_sched.sv
// Per-pixel overlay scheduler: picks sprite ROM or camera for every pixel,
// drives the ROM read and emits the composed pixel three cycles after the
// timing generator's strobe. Overlay position/enable changes are staged in
// shadow registers and only take effect at end-of-frame.
// Optional build macro OVL_COLORKEY_EN: sprite pixels equal to COLOR_KEY
// become transparent (camera shows through).
//
// state     | meaning
// S_IDLE    | no staged config, cfg_ready=1
// S_PENDING | shadow holds an accepted config waiting for end-of-frame
module vga_overlay_sched #(
   parameter int H_DISP     = 1024,
   parameter int V_DISP     = 768,
   parameter int PIC_WIDTH  = 64,
   parameter int PIC_HEIGHT = 64,
   parameter int ADDR_W     = 12
`ifdef OVL_COLORKEY_EN
   ,
   parameter logic [23:0] COLOR_KEY = 24'hFF00FF
`endif
) (
   input  logic            clk_in,
   input  logic            rst_n,
   vga_overlay_sched_if.slave bus
);

   localparam int          LOG_W  = $clog2(PIC_WIDTH);
   localparam int          LOG_H  = $clog2(PIC_HEIGHT);
   localparam logic [11:0] X_MAX  = 12'(H_DISP - PIC_WIDTH);
   localparam logic [11:0] Y_MAX  = 12'(V_DISP - PIC_HEIGHT);
   localparam logic [11:0] X_LAST = 12'(H_DISP - 1);
   localparam logic [11:0] Y_LAST = 12'(V_DISP - 1);
   localparam logic [11:0] W_SPAN = 12'(PIC_WIDTH);
   localparam logic [11:0] H_SPAN = 12'(PIC_HEIGHT);

   typedef enum logic {S_IDLE, S_PENDING} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_load;
   logic              w_apply;
   logic              w_cfg_ready;

   logic [11:0]       r_shd_x;
   logic [11:0]       r_shd_y;
   logic              r_shd_en;
   logic [11:0]       r_ovl_x;
   logic [11:0]       r_ovl_y;
   logic              r_ovl_en;

   logic [11:0]       w_clamp_x;
   logic [11:0]       w_clamp_y;
   logic [11:0]       w_dx;
   logic [11:0]       w_dy;
   logic              w_hit;
   logic              w_eof;
   logic [ADDR_W-1:0] w_addr;

   logic              r_rom_en;
   logic [ADDR_W-1:0] r_rom_addr;
   logic              r_valid_d1;
   logic              r_valid_d2;
   logic              r_hit_d2;
   logic [23:0]       w_pix;
   logic [23:0]       r_pix_data;
   logic              r_pix_valid;
   logic [15:0]       r_frame_cnt;
   logic              r_frame_tick;

   assign w_eof     = bus.data_en && (bus.x_pos == X_LAST) && (bus.y_pos == Y_LAST);
   assign w_clamp_x = (bus.cfg_x > X_MAX) ? X_MAX : bus.cfg_x;
   assign w_clamp_y = (bus.cfg_y > Y_MAX) ? Y_MAX : bus.cfg_y;

   // Offsets wrap when the pixel lies left/above the window; the >= terms
   // reject those cases before the span compare matters.
   assign w_dx   = bus.x_pos - r_ovl_x;
   assign w_dy   = bus.y_pos - r_ovl_y;
   assign w_hit  = bus.data_en && r_ovl_en &&
                   (bus.x_pos >= r_ovl_x) && (w_dx < W_SPAN) &&
                   (bus.y_pos >= r_ovl_y) && (w_dy < H_SPAN);
   assign w_addr = ADDR_W'({w_dy[LOG_H-1:0], w_dx[LOG_W-1:0]});

   // Config FSM state register
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Config FSM next state, accept/apply strobes and ready
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_apply     = 1'b0;
      w_cfg_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cfg_ready = 1'b1;
            if (bus.cfg_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_PENDING;
            end
         end
         S_PENDING: begin
            if (w_eof) begin
               w_apply     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shadow capture on accept, shadow-to-active copy at end-of-frame
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_shd_x  <= 12'd0;
         r_shd_y  <= 12'd0;
         r_shd_en <= 1'b0;
         r_ovl_x  <= 12'd0;
         r_ovl_y  <= 12'd0;
         r_ovl_en <= 1'b0;
      end else begin
         if (w_load) begin
            r_shd_x  <= w_clamp_x;
            r_shd_y  <= w_clamp_y;
            r_shd_en <= bus.cfg_ovl_en;
         end
         if (w_apply) begin
            r_ovl_x  <= r_shd_x;
            r_ovl_y  <= r_shd_y;
            r_ovl_en <= r_shd_en;
         end
      end
   end

   // Pixel select at the output stage; hit implies valid
   always_comb begin
      w_pix = 24'h0;
      if (r_hit_d2)        w_pix = bus.rom_q;
      else if (r_valid_d2) w_pix = bus.cam_data;
`ifdef OVL_COLORKEY_EN
      if (r_hit_d2 && (bus.rom_q == COLOR_KEY)) w_pix = bus.cam_data;
`endif
   end

   // Free-running three-stage pixel pipeline and frame bookkeeping
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_rom_en     <= 1'b0;
         r_rom_addr   <= '0;
         r_valid_d1   <= 1'b0;
         r_valid_d2   <= 1'b0;
         r_hit_d2     <= 1'b0;
         r_pix_data   <= 24'h0;
         r_pix_valid  <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_frame_tick <= 1'b0;
      end else begin
         r_rom_en    <= w_hit;
         if (w_hit) r_rom_addr <= w_addr;
         r_valid_d1  <= bus.data_en;
         r_valid_d2  <= r_valid_d1;
         r_hit_d2    <= r_rom_en;
         r_pix_data  <= w_pix;
         r_pix_valid <= r_valid_d2;
         r_frame_tick <= w_eof;
         if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign bus.cfg_ready  = w_cfg_ready;
   assign bus.rom_en     = r_rom_en;
   assign bus.rom_addr   = r_rom_addr;
   assign bus.pix_data   = r_pix_data;
   assign bus.pix_valid  = r_pix_valid;
   assign bus.frame_cnt  = r_frame_cnt;
   assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_overlay_sched.sv
// Bench for vga_overlay_sched: acts as timing generator, camera source and
// sprite ROM. Frames are scanned sparsely (a window around the overlay plus
// random pixels and gaps, then the end-of-frame pixel) to keep runtime short.
module tb_vga_overlay_sched;

   localparam logic [23:0] KEY = 24'hFF00FF;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;

   vga_overlay_sched_if #(.ADDR_W(12)) vif();

   vga_overlay_sched u_dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (vif.slave)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp   = 0;
   int n_fail  = 0;
   int n_romen = 0;
   int n_tick  = 0;
   bit hs_next   = 1'b0;
   bit cam_fixed = 1'b0;

   function automatic logic [23:0] rom_word(input logic [11:0] a);
      if (a == 12'd520)       return 24'h123456;
      else if ((a % 7) == 3)  return KEY;
      else                    return {a, a ^ 12'h5A5};
   endfunction

   // sprite ROM with one-cycle read latency
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)          vif.rom_q <= 24'h0;
      else if (vif.rom_en) vif.rom_q <= rom_word(vif.rom_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model + per-cycle compare
   initial begin : mdl
      bit m_pend, m_sen, m_aen, de, hit, eof, exp_pv;
      int m_sx, m_sy, m_ax, m_ay, m_cnt, m_addr, x, y;
      bit h_de[2], h_hit[2];
      int h_addr[2];
      logic [23:0] exp_pix;
      m_pend = 0; m_sen = 0; m_aen = 0; m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0;
      m_cnt = 0; m_addr = 0; h_de = '{0, 0}; h_hit = '{0, 0}; h_addr = '{0, 0};
      forever begin
         @(posedge clk_in); #1;
         if (!rst_n) begin
            m_pend = 0; m_sen = 0; m_aen = 0; m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0;
            m_cnt = 0; m_addr = 0; h_de = '{0, 0}; h_hit = '{0, 0}; h_addr = '{0, 0};
            chk("rst_rom_en",     32'(vif.rom_en),     32'd0);
            chk("rst_rom_addr",   32'(vif.rom_addr),   32'd0);
            chk("rst_pix_data",   32'(vif.pix_data),   32'd0);
            chk("rst_pix_valid",  32'(vif.pix_valid),  32'd0);
            chk("rst_cfg_ready",  32'(vif.cfg_ready),  32'd1);
            chk("rst_frame_cnt",  32'(vif.frame_cnt),  32'd0);
            chk("rst_frame_tick", 32'(vif.frame_tick), 32'd0);
         end else begin
            de  = vif.data_en;
            x   = int'(vif.x_pos);
            y   = int'(vif.y_pos);
            hit = de && m_aen && x >= m_ax && x < m_ax + 64 && y >= m_ay && y < m_ay + 64;
            eof = de && x == 1023 && y == 767;
            if (hit) m_addr = (y - m_ay) * 64 + (x - m_ax);
            if (h_hit[1]) begin
               exp_pix = rom_word(12'(h_addr[1]));
`ifdef OVL_COLORKEY_EN
               if (exp_pix == KEY) exp_pix = vif.cam_data;
`endif
            end else if (h_de[1]) exp_pix = vif.cam_data;
            else                  exp_pix = 24'h0;
            exp_pv = h_de[1];
            h_de[1] = h_de[0];   h_hit[1] = h_hit[0];   h_addr[1] = h_addr[0];
            h_de[0] = de;        h_hit[0] = hit;        h_addr[0] = m_addr;
            if (eof) m_cnt = (m_cnt + 1) % 65536;
            if (m_pend && eof) begin
               m_ax = m_sx; m_ay = m_sy; m_aen = m_sen; m_pend = 0;
            end else if (!m_pend && vif.cfg_valid) begin
               m_sx = (int'(vif.cfg_x) > 960) ? 960 : int'(vif.cfg_x);
               m_sy = (int'(vif.cfg_y) > 704) ? 704 : int'(vif.cfg_y);
               m_sen = vif.cfg_ovl_en;
               m_pend = 1;
            end
            if (vif.rom_en)     n_romen++;
            if (vif.frame_tick) n_tick++;
            chk("rom_en",     32'(vif.rom_en),     32'(hit));
            chk("rom_addr",   32'(vif.rom_addr),   32'(m_addr));
            chk("frame_tick", 32'(vif.frame_tick), 32'(eof));
            chk("frame_cnt",  32'(vif.frame_cnt),  32'(m_cnt));
            chk("cfg_ready",  32'(vif.cfg_ready),  32'(!m_pend));
            chk("pix_valid",  32'(vif.pix_valid),  32'(exp_pv));
            chk("pix_data",   32'(vif.pix_data),   32'(exp_pix));
         end
      end
   end

   task automatic cyc(input bit de, input logic [11:0] x, input logic [11:0] y);
      @(negedge clk_in);
      if (hs_next) vif.cfg_valid = 1'b0;
      vif.data_en  = de;
      vif.x_pos    = x;
      vif.y_pos    = y;
      vif.cam_data = cam_fixed ? 24'hC0FFEE : 24'($urandom);
      hs_next = vif.cfg_valid && vif.cfg_ready;
   endtask

   // call only directly after cyc, before the next rising edge
   task automatic post(input int cx, input int cy, input bit en);
      vif.cfg_x      = 12'(cx);
      vif.cfg_y      = 12'(cy);
      vif.cfg_ovl_en = en;
      vif.cfg_valid  = 1'b1;
      hs_next = vif.cfg_ready;
   endtask

   task automatic settle();
      @(posedge clk_in); #2;
   endtask

   task automatic frame(input int x0, input int x1, input int y0, input int y1, input bit do_eof);
      bit last_eof = 1'b0;
      for (int yy = y0; yy <= y1; yy++) begin
         for (int xx = x0; xx <= x1; xx++) begin
            int r = int'($urandom_range(99));
            if (r < 8)       cyc(1'b0, 12'($urandom_range(4095)), 12'($urandom_range(4095)));
            else if (r < 12) cyc(1'b1, 12'($urandom_range(1022)), 12'($urandom_range(767)));
            cyc(1'b1, 12'(xx), 12'(yy));
            last_eof = (xx == 1023 && yy == 767);
         end
      end
      if (do_eof && !last_eof) cyc(1'b1, 12'd1023, 12'd767);
   endtask

   task automatic frame_around(input int ox, input int oy);
      frame((ox < 6) ? 0 : ox - 6, (ox + 69 > 1023) ? 1023 : ox + 69,
            (oy < 4) ? 0 : oy - 4, (oy + 67 > 767) ? 767 : oy + 67, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      vif.data_en = 1'b0; vif.x_pos = 12'd0; vif.y_pos = 12'd0; vif.cam_data = 24'h0;
      vif.cfg_valid = 1'b0; vif.cfg_x = 12'd0; vif.cfg_y = 12'd0; vif.cfg_ovl_en = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;

      // two frames without configuration
      frame_around(192, 112);
      frame_around(192, 112);
      settle();
      chk("two_frames_cnt",  32'(vif.frame_cnt), 32'd2);
      chk("two_frames_tick", 32'(n_tick),        32'd2);
      chk("no_rom_en_idle",  32'(n_romen),       32'd0);

      // config accepted mid-frame, applied only at end-of-frame
      frame(186, 261, 108, 140, 1'b0);
      post(192, 112, 1'b1);
      settle();
      chk("ready_drop", 32'(vif.cfg_ready), 32'd0);
      n_romen = 0;
      frame(186, 261, 141, 181, 1'b1);
      settle();
      chk("ready_back",         32'(vif.cfg_ready), 32'd1);
      chk("no_rom_en_pending",  32'(n_romen),       32'd0);

      // window corners and latency with the overlay at (192,112)
      cam_fixed = 1'b1;
      cyc(1'b1, 12'd192, 12'd112); settle();
      chk("corner_tl_en",   32'(vif.rom_en),   32'd1);
      chk("corner_tl_addr", 32'(vif.rom_addr), 32'd0);
      cyc(1'b1, 12'd255, 12'd175); settle();
      chk("corner_br_addr", 32'(vif.rom_addr), 32'd4095);
      cyc(1'b1, 12'd200, 12'd120); settle();
      chk("lat_rom_en",   32'(vif.rom_en),   32'd1);
      chk("lat_rom_addr", 32'(vif.rom_addr), 32'd520);
      cyc(1'b0, 12'd0, 12'd0); cyc(1'b0, 12'd0, 12'd0); settle();
      chk("lat_pix_valid", 32'(vif.pix_valid), 32'd1);
      chk("lat_pix_data",  32'(vif.pix_data),  32'h123456);
      cyc(1'b1, 12'd195, 12'd112); cyc(1'b0, 12'd0, 12'd0); cyc(1'b0, 12'd0, 12'd0); settle();
`ifdef OVL_COLORKEY_EN
      chk("key_pixel", 32'(vif.pix_data), 32'hC0FFEE);
`else
      chk("key_pixel", 32'(vif.pix_data), 32'(KEY));
`endif
      cam_fixed = 1'b0;
      frame_around(192, 112);

      // second request held across an end-of-frame while pending
      cyc(1'b0, 12'd0, 12'd0);
      post(100, 50, 1'b1);
      cyc(1'b0, 12'd0, 12'd0);
      post(500, 400, 1'b1);
      settle();
      chk("held_ready_low", 32'(vif.cfg_ready), 32'd0);
      frame_around(192, 112);
      settle();
      chk("held_ready_eof", 32'(vif.cfg_ready), 32'd1);
      cyc(1'b0, 12'd0, 12'd0); settle();
      chk("held_accepted", 32'(vif.cfg_ready), 32'd0);
      cyc(1'b1, 12'd100, 12'd50); settle();
      chk("first_visible", 32'(vif.rom_en), 32'd1);
      frame_around(100, 50);
      cyc(1'b1, 12'd500, 12'd400); settle();
      chk("second_visible", 32'(vif.rom_en), 32'd1);

      // clamp request, applied for the next frame
      cyc(1'b0, 12'd0, 12'd0);
      post(1000, 760, 1'b1);
      frame_around(500, 400);
      cyc(1'b1, 12'd959, 12'd704); settle();
      chk("clamp_left_out", 32'(vif.rom_en), 32'd0);
      cyc(1'b1, 12'd960, 12'd703); settle();
      chk("clamp_top_out",  32'(vif.rom_en), 32'd0);
      cyc(1'b1, 12'd960, 12'd704); settle();
      chk("clamp_tl_addr",  32'(vif.rom_addr), 32'd0);
      frame_around(960, 704);
      settle();
      chk("clamp_br_en",   32'(vif.rom_en),   32'd1);
      chk("clamp_br_addr", 32'(vif.rom_addr), 32'd4095);

      // reset mid-frame drops the staged config
      cyc(1'b0, 12'd0, 12'd0);
      post(400, 300, 1'b1);
      frame(394, 469, 296, 330, 1'b0);
      @(negedge clk_in);
      rst_n = 1'b0;
      vif.cfg_valid = 1'b0;
      hs_next = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      n_romen = 0;
      frame_around(400, 300);
      settle();
      chk("post_rst_cnt",   32'(vif.frame_cnt), 32'd1);
      chk("post_rst_romen", 32'(n_romen),       32'd0);
      chk("post_rst_ready", 32'(vif.cfg_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_overlay_sched.md
Name: vga_overlay_sched

Overview:
- Per-pixel overlay scheduler between the VGA timing generator and the pixel path.
- Takes the early-pixel strobe and coordinates (data_en, x_pos, y_pos) from the timing generator. Decides per pixel whether the 64x64 sprite ROM or the camera stream owns the pixel.
- Sequences the ROM read (rom_en/rom_addr) and emits the composed 24-bit pixel.
- Overlay position/enable are reconfigured through a valid/ready port. Updates are applied only at end-of-frame, so a frame never tears.

Parameters:
- H_DISP, 1024, active pixels per line
- V_DISP, 768, active lines per frame
- PIC_WIDTH, 64, sprite width; must be a power of two
- PIC_HEIGHT, 64, sprite height; must be a power of two
- ADDR_W, 12, ROM address width; equals log2(PIC_WIDTH*PIC_HEIGHT)

Ports:
- clk_in  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- data_en  in  1  early pixel strobe from the timing generator
- x_pos  in  12  active-area column; valid when data_en=1
- y_pos  in  12  active-area line; valid when data_en=1
- cam_data  in  24  camera pixel; upstream aligns it to cycle t+2 for the data_en sampled at t
- rom_q  in  24  sprite ROM data; 1-cycle synchronous read latency
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM read address
- pix_data  out  24  composed RGB888 pixel
- pix_valid  out  1  pix_data is valid
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  scheduler can accept a configuration
- cfg_x  in  12  requested overlay left column
- cfg_y  in  12  requested overlay top line
- cfg_ovl_en  in  1  requested overlay enable
- frame_cnt  out  16  completed-frame counter
- frame_tick  out  1  one-cycle pulse at end-of-frame

Behaviour:
- Reset (async, rst_n=0) drives these values:
  - rom_en=0, rom_addr=0, pix_data=0, pix_valid=0
  - cfg_ready=1, frame_cnt=0, frame_tick=0
  - active registers: ovl_x=0, ovl_y=0, ovl_en=0
  - shadow registers cleared
  - pipeline valid/hit bits cleared
- Reset mid-frame discards the pending config and all in-flight pixels.
- End-of-frame (EOF) event: data_en=1 && x_pos==H_DISP-1 && y_pos==V_DISP-1.
  - frame_tick=1 in the cycle after EOF is sampled.
  - frame_cnt increments in that same cycle and wraps 0xFFFF->0.
- Config FSM, states IDLE and PENDING:
  - IDLE: cfg_ready=1. When cfg_valid&&cfg_ready:
    - load shadow registers with the clamped values;
    - next state PENDING.
  - PENDING: cfg_ready=0 and cfg_valid is ignored. On EOF:
    - copy shadow -> active (visible from the next frame's first pixel);
    - next state IDLE.
  - Acceptance in the same cycle as an EOF: the config is applied at the following EOF, not the current one.
- Clamping of accepted values:
  - x = min(cfg_x, H_DISP-PIC_WIDTH), so 960 with defaults.
  - y = min(cfg_y, V_DISP-PIC_HEIGHT), so 704 with defaults.
- Hit test at cycle t: hit = data_en && ovl_en && ovl_x<=x_pos<ovl_x+PIC_WIDTH && ovl_y<=y_pos<ovl_y+PIC_HEIGHT.
- Pipeline, fixed 3-cycle latency:
  - t+1: rom_en=hit (registered). rom_addr = {(y_pos-ovl_y)[log2 H-1:0], (x_pos-ovl_x)[log2 W-1:0]} when hit, else rom_addr holds its previous value. valid_d1=data_en.
  - t+2: rom_q and cam_data valid; hit_d2 and valid_d2 carried through.
  - t+3 (registered outputs):
    - pix_valid=valid_d2;
    - pix_data=rom_q if hit_d2, else cam_data if valid_d2, else 24'h0.
- Pipeline is free-running with no stall. Gaps in data_en simply propagate as pix_valid=0.
- All coordinate arithmetic is 12-bit unsigned. Comparisons are evaluated only when data_en=1, so no underflow affects outputs.

Optional Feature:
- OVL_COLORKEY_EN defined:
  - adds parameter COLOR_KEY, default 24'hFF00FF;
  - at t+3, if hit_d2 && rom_q==COLOR_KEY then pix_data=cam_data (transparent sprite pixel).
- Undefined: the sprite is fully opaque and COLOR_KEY does not exist.

Test Plan:
- Reset, then 2 full frames with no config -> rom_en never 1; pix_data==cam_data whenever pix_valid; frame_cnt=2; exactly 2 frame_tick pulses.
- Config x=192,y=112,en=1 accepted mid-frame:
  - cfg_ready drops the next cycle;
  - rest of the frame has no rom_en;
  - next frame: rom_en first at x=192,y=112 with rom_addr=0; rom_addr=4095 at x=255,y=175; cfg_ready returns 1 the cycle after EOF.
- Latency check: single data_en at x=200,y=120 with overlay at (192,112) -> rom_en at t+1 with rom_addr=8*64+8=520; pix_valid=1 and pix_data=rom_q at t+3.
- cfg_valid held asserted across an EOF while PENDING -> second request accepted only after the apply; second value visible one frame later.
- Clamp: cfg_x=1000, cfg_y=760 -> overlay occupies columns 960..1023 and lines 704..767; rom_addr=4095 at (1023,767).
- OVL_COLORKEY_EN build: rom_q=24'hFF00FF inside the window -> pix_data=cam_data; rom_q=24'h123456 -> pix_data=24'h123456.
